// File: rtl/ram_sync_dp_clr.sv
// Dual-port synchronous RAM: port A read/write, port B read-only, with a
// selectable read-during-write policy and a post-reset clear sweep.
module ram_sync_dp_clr #(
   parameter int WIDTH          = 16,
   parameter int ADDR_W         = 12,
   parameter int DEPTH          = 4096,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  data,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   input  logic [ADDR_W-1:0] address_b,
   output logic [WIDTH-1:0]  out_b,
   output logic              busy
);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
   localparam bit                WRITE_FIRST = (RDW_MODE != 0);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_next;

   logic              w_clearing;
   logic              w_a_in_range;
   logic              w_b_in_range;
   logic              w_user_wr;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [WIDTH-1:0]  w_wr_data;
   logic              w_a_bypass;
   logic              w_b_bypass;

   logic [WIDTH-1:0]  r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RESET_STATE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latches.
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      case (r_state)
         ST_CLEAR: begin
            if (r_ptr == LAST_ADDR) begin
               w_state_next = ST_IDLE;
               w_ptr_next   = '0;
            end else begin
               w_ptr_next = r_ptr + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign w_clearing   = (r_state == ST_CLEAR);
   assign busy         = w_clearing;

   // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
   assign w_a_in_range = ({1'b0, address}   < DEPTH_EXT);
   assign w_b_in_range = ({1'b0, address_b} < DEPTH_EXT);

   // The clear engine and port A share the single write port of the array.
   assign w_user_wr    = load && w_a_in_range;
   assign w_wr_en      = !reset && (w_clearing || w_user_wr);
   assign w_wr_addr    = w_clearing ? r_ptr : address;
   assign w_wr_data    = w_clearing ? '0 : data;

   // Write-first forwarding lives outside the array so it still maps to block RAM.
   assign w_a_bypass   = WRITE_FIRST && w_user_wr;
   assign w_b_bypass   = WRITE_FIRST && w_user_wr && (address_b == address);

   // NOTE: the array itself is never reset; zeroing is the clear engine's job.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_clearing) begin
         out   <= '0;
         out_b <= '0;
      end else begin
         if (!w_a_in_range) begin
            out <= '0;
         end else if (w_a_bypass) begin
            out <= data;
         end else begin
            out <= r_mem[address];
         end

         if (!w_b_in_range) begin
            out_b <= '0;
         end else if (w_b_bypass) begin
            out_b <= data;
         end else begin
            out_b <= r_mem[address_b];
         end
      end
   end

endmodule

// File: tb/tb_ram_sync_dp_clr.sv
// Bench for ram_sync_dp_clr: three instances (read-first, write-first, no-clear)
// share one stimulus stream and are each checked against a word-level model.
module tb_ram_sync_dp_clr;

   localparam int       WIDTH  = 16;
   localparam int       ADDR_W = 5;
   localparam int       DEPTH  = 20;
   localparam int       N_DUT  = 3;
   localparam bit [2:0] RDW    = 3'b010;
   localparam bit [2:0] COR    = 3'b011;

   logic              clk = 1'b0;
   logic              reset;
   logic              load;
   logic [WIDTH-1:0]  data;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] address_b;

   logic [WIDTH-1:0]  o_out  [N_DUT];
   logic [WIDTH-1:0]  o_outb [N_DUT];
   logic              o_busy [N_DUT];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, one slice per instance.
   logic [WIDTH-1:0] m_mem    [N_DUT][DEPTH];
   bit               m_known  [N_DUT][DEPTH];
   int               m_clr    [N_DUT];
   logic [WIDTH-1:0] m_out    [N_DUT];
   logic [WIDTH-1:0] m_outb   [N_DUT];
   bit               m_out_k  [N_DUT];
   bit               m_outb_k [N_DUT];
   bit               m_valid  [N_DUT];

   always #5 clk = ~clk;

   ram_sync_dp_clr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk(clk), .reset(reset), .data(data), .load(load), .address(address),
      .out(o_out[0]), .address_b(address_b), .out_b(o_outb[0]), .busy(o_busy[0]));

   ram_sync_dp_clr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .reset(reset), .data(data), .load(load), .address(address),
      .out(o_out[1]), .address_b(address_b), .out_b(o_outb[1]), .busy(o_busy[1]));

   ram_sync_dp_clr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_dut2 (
      .clk(clk), .reset(reset), .data(data), .load(load), .address(address),
      .out(o_out[2]), .address_b(address_b), .out_b(o_outb[2]), .busy(o_busy[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Word-level model of one clock edge, evaluated on the inputs held over that edge.
   task automatic model_step();
      for (int k = 0; k < N_DUT; k++) begin
         if (reset) begin
            m_valid[k]  = 1'b1;
            m_out[k]    = '0;
            m_outb[k]   = '0;
            m_out_k[k]  = 1'b1;
            m_outb_k[k] = 1'b1;
            m_clr[k]    = COR[k] ? DEPTH : 0;
         end else if (m_valid[k] && m_clr[k] > 0) begin
            m_mem[k][DEPTH - m_clr[k]]   = '0;
            m_known[k][DEPTH - m_clr[k]] = 1'b1;
            m_clr[k]--;
            m_out[k]  = '0;
            m_outb[k] = '0;
         end else if (m_valid[k]) begin
            int  a   = int'(address);
            int  b   = int'(address_b);
            bit  wr  = load && (a < DEPTH);
            if (a >= DEPTH) begin
               m_out[k] = '0;  m_out_k[k] = 1'b1;
            end else if (wr && RDW[k]) begin
               m_out[k] = data; m_out_k[k] = 1'b1;
            end else begin
               m_out[k] = m_mem[k][a]; m_out_k[k] = m_known[k][a];
            end
            if (b >= DEPTH) begin
               m_outb[k] = '0;  m_outb_k[k] = 1'b1;
            end else if (wr && RDW[k] && a == b) begin
               m_outb[k] = data; m_outb_k[k] = 1'b1;
            end else begin
               m_outb[k] = m_mem[k][b]; m_outb_k[k] = m_known[k][b];
            end
            if (wr) begin
               m_mem[k][a]   = data;
               m_known[k][a] = 1'b1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < N_DUT; k++) begin
         if (m_valid[k]) begin
            check($sformatf("model_busy%0d", k), 32'(o_busy[k]), 32'(m_clr[k] > 0));
            if (m_out_k[k])  check($sformatf("model_out%0d", k),  32'(o_out[k]),  32'(m_out[k]));
            if (m_outb_k[k]) check($sformatf("model_outb%0d", k), 32'(o_outb[k]), 32'(m_outb[k]));
         end
      end
   end

   task automatic apply(input logic r, input logic ld, input logic [WIDTH-1:0] d,
                        input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ab);
      reset     = r;
      load      = ld;
      data      = d;
      address   = a;
      address_b = ab;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic nop();
      apply(1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; data = '0; address = '0; address_b = '0;

      // Bring-up clear, then fill with random words so the next sweep has something to erase.
      apply(1'b1, 1'b0, '0, '0, '0);
      repeat (DEPTH) nop();
      check("init_busy0", 32'(o_busy[0]), 32'd0);
      for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b1, 16'($urandom), 5'(i), 5'(i));

      // Clear sweep.
      apply(1'b1, 1'b0, '0, '0, '0);
      check("rst_busy2", 32'(o_busy[2]), 32'd0);
      check("rst_out2",  32'(o_out[2]),  32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         check("sweep_busy0", 32'(o_busy[0]), 32'd1);
         check("sweep_busy1", 32'(o_busy[1]), 32'd1);
         check("sweep_out0",  32'(o_out[0]),  32'd0);
         nop();
      end
      check("sweep_done_busy0", 32'(o_busy[0]), 32'd0);
      check("sweep_done_busy1", 32'(o_busy[1]), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, 1'b0, '0, 5'(i), 5'(DEPTH - 1 - i));
         check("cleared_a0", 32'(o_out[0]),  32'd0);
         check("cleared_b0", 32'(o_outb[0]), 32'd0);
         check("cleared_a1", 32'(o_out[1]),  32'd0);
      end

      // Basic read/write on both ports.
      apply(1'b0, 1'b1, 16'hBEEF, 5'd3, 5'd0);
      apply(1'b0, 1'b1, 16'h1234, 5'd19, 5'd0);
      apply(1'b0, 1'b0, '0, 5'd3, 5'd19);
      for (int k = 0; k < N_DUT; k++) begin
         check("basic_a", 32'(o_out[k]),  32'h0000BEEF);
         check("basic_b", 32'(o_outb[k]), 32'h00001234);
      end

      // Read-during-write on address 7.
      apply(1'b0, 1'b1, 16'h00AA, 5'd7, 5'd0);
      apply(1'b0, 1'b1, 16'h5555, 5'd7, 5'd7);
      check("rdw_rf_a0", 32'(o_out[0]),  32'h000000AA);
      check("rdw_rf_b0", 32'(o_outb[0]), 32'h000000AA);
      check("rdw_wf_a1", 32'(o_out[1]),  32'h00005555);
      check("rdw_wf_b1", 32'(o_outb[1]), 32'h00005555);
      check("rdw_rf_a2", 32'(o_out[2]),  32'h000000AA);
      apply(1'b0, 1'b0, '0, 5'd7, 5'd7);
      for (int k = 0; k < N_DUT; k++) begin
         check("rdw_after_a", 32'(o_out[k]),  32'h00005555);
         check("rdw_after_b", 32'(o_outb[k]), 32'h00005555);
      end

      // Out-of-range write must not alias onto address 5.
      apply(1'b0, 1'b1, 16'h0505, 5'd5, 5'd0);
      apply(1'b0, 1'b1, 16'hFFFF, 5'd25, 5'd5);
      for (int k = 0; k < N_DUT; k++) begin
         check("oor_wr_a", 32'(o_out[k]),  32'd0);
         check("oor_wr_b", 32'(o_outb[k]), 32'h00000505);
      end
      apply(1'b0, 1'b0, '0, 5'd5, 5'd31);
      for (int k = 0; k < N_DUT; k++) begin
         check("oor_alias_a", 32'(o_out[k]),  32'h00000505);
         check("oor_rd_b",    32'(o_outb[k]), 32'd0);
      end

      // Reset at sweep cycle 10 restarts the full sweep; writes during it are dropped.
      apply(1'b1, 1'b0, '0, '0, '0);
      repeat (10) nop();
      apply(1'b1, 1'b0, '0, '0, '0);
      for (int i = 0; i < DEPTH; i++) begin
         check("restart_busy0", 32'(o_busy[0]), 32'd1);
         apply(1'b0, 1'b1, 16'h7777, 5'd2, 5'd2);
      end
      check("restart_done_busy0", 32'(o_busy[0]), 32'd0);
      apply(1'b0, 1'b0, '0, 5'd2, 5'd2);
      check("restart_a0", 32'(o_out[0]),  32'd0);
      check("restart_b1", 32'(o_outb[1]), 32'd0);
      check("restart_a2", 32'(o_out[2]),  32'h00007777);

      // Without the clear engine, reset leaves the array alone.
      apply(1'b0, 1'b1, 16'h4321, 5'd4, 5'd0);
      apply(1'b1, 1'b0, '0, 5'd4, 5'd4);
      check("noclr_busy2", 32'(o_busy[2]), 32'd0);
      check("noclr_out2",  32'(o_out[2]),  32'd0);
      apply(1'b0, 1'b0, '0, 5'd4, 5'd4);
      check("noclr_keep_a2", 32'(o_out[2]),  32'h00004321);
      check("noclr_keep_b2", 32'(o_outb[2]), 32'h00004321);
      check("noclr_busy2b",  32'(o_busy[2]), 32'd0);
      repeat (DEPTH) nop();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_sync_dp_clr.md
Name: ram_sync_dp_clr

Overview:
- Parametrised successor to the team's 16-bit synchronous single-port RAM.
- Adds a second independent read-only port (B), a selectable read-during-write policy, out-of-range address handling, and a hardware clear engine that zeroes the whole array after reset.
- Used as data/screen memory in the Hack system where port A is the CPU data path and port B is a display/debug read tap.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 12, address width in bits.
- DEPTH, 4096, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, read-during-write policy when a read hits the address being written: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1, 1 = sweep-clear array to zero after reset; 0 = no clear, array contents undefined after power-up and untouched by reset.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  WIDTH  port A write data.
- load  in  1  port A write enable.
- address  in  ADDR_W  port A read/write address.
- out  out  WIDTH  port A registered read data.
- address_b  in  ADDR_W  port B read address.
- out_b  out  WIDTH  port B registered read data.
- busy  out  1  high while clear engine owns the array; writes ignored, reads return 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset, sampled on a rising edge:
  - out = 0, out_b = 0.
  - If CLEAR_ON_RESET=1: state = CLEAR, clear pointer = 0, busy = 1.
  - If CLEAR_ON_RESET=0: state = IDLE, busy = 0, array untouched.
- Reset has priority over everything, including mid-clear; the sweep restarts at address 0.
- States:
  - IDLE: normal operation.
  - CLEAR, each non-reset edge: write 0 to array[ptr]; if ptr == DEPTH-1 go to IDLE, else ptr+1.
  - CLEAR lasts exactly DEPTH edges after reset deasserts. busy drops at the edge that writes DEPTH-1; the first user write is accepted on the following edge.
- In CLEAR: load ignored, out and out_b held at 0.
- IDLE, port A:
  - If load and address < DEPTH: array[address] <= data.
  - out <= array[address], 1-cycle latency (registered output, same as existing RAM4K).
- IDLE, port B: out_b <= array[address_b], 1-cycle latency; never writes.
- Out-of-range address (>= DEPTH): writes dropped with no aliasing; reads return 0 at the next edge.
- Read-during-write, load=1 on an in-range address:
  - Port A reading the same address: RDW_MODE=0 gives the old word; RDW_MODE=1 gives data.
  - Port B with address_b == address: same policy as port A.
  - Different addresses: no interaction.
- Outputs update every IDLE edge, whether or not load is set. No output enables.
- Array is inferable as block RAM. In write-first mode, bypass muxing is allowed outside the array.

Test Plan (bench params WIDTH=16, ADDR_W=5, DEPTH=20):
- Clear sweep: preload random data (CLEAR_ON_RESET=1), pulse reset 1 cycle -> busy high exactly 20 cycles and out=0 throughout; afterwards all addresses 0..19 read 0 on both ports.
- Basic R/W: write 0xBEEF@3, 0x1234@19, then read A@3 and B@19 in the same cycle -> next cycle out=0xBEEF, out_b=0x1234.
- Read-during-write, address 7 holds 0x00AA; load=1, data=0x5555, address=7, address_b=7:
  - RDW_MODE=0 -> out=out_b=0x00AA next cycle.
  - RDW_MODE=1 -> out=out_b=0x5555.
  - Read of 7 one cycle later returns 0x5555 in both modes.
- Out-of-range: write 0xFFFF@25 -> out=0; addresses 5 and 25-20=5 unchanged (no aliasing); B read of 31 -> out_b=0.
- Reset mid-clear: assert reset at sweep cycle 10 for 1 cycle -> busy restarts and stays high 20 more cycles. load=1 with 0x7777@2 during the sweep -> address 2 reads 0 afterwards.
- CLEAR_ON_RESET=0: write 0x4321@4, pulse reset -> busy stays 0, out=0 right after reset, read of 4 returns 0x4321.
